sw_debounce: RTL and testbench



---
 rtl/sw_debounce_pkg.sv | 18 +
 rtl/sw_debounce_bit.sv | 92 +++++++++
 rtl/sw_debounce.sv | 42 ++++
 tb/tb_sw_debounce.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Purpose: shared board timing and FSM encodings for the switch debouncer.
// Latency: n/a (constants only).
// Backpressure: n/a (no flow control in this block).
package sw_debounce_pkg;

   // Board timing lives here so that retargeting the clock only touches one file.
   localparam int CLK_FREQ_HZ = 50_000_000;
   localparam int DEBOUNCE_MS = 20;

   // 20 ms at 50 MHz = 1,000,000 cycles; CNT_W must cover this count.
   localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
   localparam int DEFAULT_CNT_W           = 20;

   // Per-bit debounce FSM encoding (kept as plain constants for legacy tools).
   localparam logic [0:0] STABLE = 1'b0;
   localparam logic [0:0] WAIT   = 1'b1;

endpackage

// File: rtl/sw_debounce_bit.sv
// Purpose: synchronise and debounce one switch bit, emitting registered rise/fall pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from the first edge sampling a new level.
// Backpressure: none; pulses are single-cycle and must be consumed when presented.
module sw_debounce_bit
   import sw_debounce_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int   CNT_W           = DEFAULT_CNT_W,
   parameter logic RESET_BIT       = 1'b0
)(
   input  logic clk,
   input  logic reset,
   input  logic sw_async,
   output logic sw_clean,
   output logic sw_rise,
   output logic sw_fall
);

   // Terminal count: the counter never goes past this value, so it cannot wrap.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_out;
   logic [0:0]             state;
   logic [CNT_W-1:0]       cnt;
   logic                   differs;
   logic                   accept;

   assign sync_out = sync[SYNC_STAGES-1];
   assign differs  = (sync_out != sw_clean);

   // A new level is accepted only when it has held for the full debounce window.
   assign accept = (state == WAIT) && differs && (cnt == CNT_LAST);

   // Metastability synchroniser: shift the raw pin through SYNC_STAGES flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= {SYNC_STAGES{RESET_BIT}};
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], sw_async};
      end
   end

   // Debounce FSM and stability counter; any bounce back to the current level restarts.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= STABLE;
         cnt   <= '0;
      end else begin
         case (state)
            STABLE: begin
               if (differs) begin
                  state <= WAIT;
                  cnt   <= CNT_W'(1);
               end else begin
                  cnt   <= '0;
               end
            end
            WAIT: begin
               if (!differs || accept) begin
                  state <= STABLE;
                  cnt   <= '0;
               end else begin
                  cnt   <= cnt + 1'b1;
               end
            end
            default: begin
               state <= STABLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Clean level flips on acceptance; the pulses are registered alongside it so they
   // coincide with the first cycle sw_clean shows the new value.
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_clean <= RESET_BIT;
         sw_rise  <= 1'b0;
         sw_fall  <= 1'b0;
      end else begin
         sw_rise <= accept & ~sw_clean;
         sw_fall <= accept &  sw_clean;
         if (accept) begin
            sw_clean <= ~sw_clean;
         end
      end
   end

endmodule

// File: rtl/sw_debounce.sv
// Purpose: condition WIDTH raw switch pins into clean levels plus rise/fall pulses for the PIO.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges per accepted level change; all outputs registered.
// Backpressure: none; pulses and changed are single-cycle strobes.
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int               WIDTH           = 3,
   parameter int               SYNC_STAGES     = 2,
   parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int               CNT_W           = DEFAULT_CNT_W,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_async,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             changed
);

   // Bits are fully independent; each gets its own synchroniser, counter and FSM.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .RESET_BIT       (RESET_VALUE[i])
      ) u_bit (
         .clk      (clk),
         .reset    (reset),
         .sw_async (sw_async[i]),
         .sw_clean (sw_clean[i]),
         .sw_rise  (sw_rise[i]),
         .sw_fall  (sw_fall[i])
      );
   end

   // Pulses are already registered, so the OR stays a single-cycle strobe.
   assign changed = |{sw_rise, sw_fall};

endmodule

// File: tb/tb_sw_debounce.sv
// Purpose: directed stimulus with an expected-event queue checked by an independent output monitor.
// Latency: each accepted change is expected exactly 10 edges after the first sampling edge.
// Backpressure: n/a.
module tb_sw_debounce;

   logic       clk;
   logic       reset;
   logic [2:0] sw_async;
   logic [2:0] sw_clean;
   logic [2:0] sw_rise;
   logic [2:0] sw_fall;
   logic       changed;

   typedef struct {
      int         cyc;
      logic [2:0] clean;
      logic [2:0] rise;
      logic [2:0] fall;
   } ev_t;

   ev_t        exp_q[$];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;
   logic       rst_q = 1'b0;
   logic [2:0] prev_clean = 3'b000;

   sw_debounce #(
      .WIDTH           (3),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (8),
      .CNT_W           (4),
      .RESET_VALUE     (3'b000)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .sw_async (sw_async),
      .sw_clean (sw_clean),
      .sw_rise  (sw_rise),
      .sw_fall  (sw_fall),
      .changed  (changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter and registered view of reset, both stable by the following negedge.
   always @(posedge clk) begin
      cyc++;
      rst_q = reset;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push(input int c, input logic [2:0] cl, input logic [2:0] r, input logic [2:0] f);
      ev_t e;
      e.cyc = c; e.clean = cl; e.rise = r; e.fall = f;
      exp_q.push_back(e);
   endtask

   // Monitor: any visible output activity must match the head of the expected queue.
   always @(negedge clk) begin
      ev_t e;
      if (rst_q) begin
         chk("rst_clean",   int'(sw_clean), 0);
         chk("rst_pulses",  int'({sw_rise, sw_fall, changed}), 0);
      end
      if (changed || (sw_rise != 3'b000) || (sw_fall != 3'b000) || (sw_clean != prev_clean)) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: clean=%b rise=%b fall=%b changed=%b, expected no activity (cycle %0d)",
                     sw_clean, sw_rise, sw_fall, changed, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("ev_cycle",   cyc, e.cyc);
            chk("ev_clean",   int'(sw_clean), int'(e.clean));
            chk("ev_rise",    int'(sw_rise),  int'(e.rise));
            chk("ev_fall",    int'(sw_fall),  int'(e.fall));
            chk("ev_changed", int'(changed),  int'((e.rise | e.fall) != 3'b000));
         end
      end
      prev_clean = sw_clean;
   end

   task automatic drive(input logic [2:0] v);
      @(negedge clk);
      sw_async = v;
   endtask

   // Bounded wait for all expected events; a timeout counts as a failed comparison.
   task automatic drain(input int max_cycles);
      for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else begin
         $display("FAIL drain_timeout: %0d events outstanding, expected 0 (cycle %0d)", exp_q.size(), cyc);
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      // Reset held with all switches high; all bits rise together after release.
      sw_async = 3'b111;
      reset    = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      push(cyc + 10, 3'b111, 3'b111, 3'b000);
      drain(40);

      // Return to all-low, then a clean step on bit 0.
      drive(3'b000);
      push(cyc + 10, 3'b000, 3'b000, 3'b111);
      drain(40);
      drive(3'b001);
      push(cyc + 10, 3'b001, 3'b001, 3'b000);
      drain(40);

      // Bounce on bit 1: high 5, low 1, then high for good.
      drive(3'b011);
      repeat (4) @(negedge clk);
      drive(3'b001);
      drive(3'b011);
      push(cyc + 10, 3'b011, 3'b010, 3'b000);
      drain(40);

      // 3-cycle glitch on bit 2 must produce no activity at all.
      drive(3'b111);
      repeat (2) @(negedge clk);
      drive(3'b011);
      repeat (20) @(negedge clk);
      chk("glitch_clean", int'(sw_clean), 3);

      // Simultaneous fall on bit 0 and rise on bit 2.
      drive(3'b110);
      push(cyc + 10, 3'b110, 3'b100, 3'b001);
      drain(40);

      // Reset in the middle of bit 0's debounce window.
      drive(3'b111);
      repeat (3) @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      push(cyc + 1, 3'b000, 3'b000, 3'b000);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      push(cyc + 10, 3'b111, 3'b111, 3'b000);
      drain(40);
      chk("final_clean", int'(sw_clean), 7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

endmodule
